fnd_scan_ctrl: RTL and testbench



---
 rtl/fnd_pkg.sv | 34 +++
 rtl/fnd_tick_gen.sv | 26 ++
 rtl/fnd_scan_ctrl.sv | 141 ++++++++++++++
 tb/tb_fnd_scan_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared types and helpers for the FND scan controller.
package fnd_pkg;

  localparam int unsigned NUM_DIGITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } state_t;

  // Next set mask bit circularly above cur; returns cur when it is the only
  // set bit (or when the mask is empty).
  function automatic logic [2:0] next_digit(input logic [2:0] cur,
                                            input logic [7:0] mask);
    logic [2:0] idx;
    logic       found;
    next_digit = cur;
    found      = 1'b0;
    for (int unsigned i = 1; i <= NUM_DIGITS; i++) begin
      idx = cur + 3'(i);
      if (!found && mask[idx]) begin
        next_digit = idx;
        found      = 1'b1;
      end
    end
  endfunction

  // Active-low one-hot anode pattern for a digit index.
  function automatic logic [7:0] onehot_low(input logic [2:0] idx);
    onehot_low = ~(8'd1 << idx);
  endfunction

endpackage

// File: rtl/fnd_tick_gen.sv
// Dwell prescaler: counts 0..DIV-1 and wraps; clr forces the count to 0.
module fnd_tick_gen #(
  parameter int unsigned DIV = 10,
  parameter int unsigned CW  = $clog2(DIV)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  output logic [CW-1:0] count,
  output logic          dwell_tick
);

  assign dwell_tick = (count == CW'(DIV - 1));

  // Free-running modulo-DIV counter with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (dwell_tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit 7-segment display.
// Optional macro FND_DIM_EN adds a 3-bit `bright` input that trims the
// anode-on portion of each DRIVE interval in eighths.
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned SCAN_HZ      = 1000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned NUM_DIGITS   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] digit_mask,
`ifdef FND_DIM_EN
  input  logic [2:0] bright,
`endif
  output logic [2:0] sel,
  output logic [7:0] an_n,
  output logic       frame_done
);

  localparam int unsigned DIV = CLK_HZ / SCAN_HZ;
  localparam int unsigned CW  = $clog2(DIV);

  if (NUM_DIGITS != fnd_pkg::NUM_DIGITS) begin : g_bad_digits
    $error("fnd_scan_ctrl: NUM_DIGITS must be 8");
  end
  if (BLANK_CYCLES < 1 || DIV < BLANK_CYCLES + 2) begin : g_bad_timing
    $error("fnd_scan_ctrl: need BLANK_CYCLES >= 1 and DIV >= BLANK_CYCLES+2");
  end

  state_t        state_q, state_n;
  logic [2:0]    sel_n;
  logic [2:0]    nd;
  logic          fd_n;
  logic [7:0]    an_nxt;
  logic          clr;
  logic          lit;
  logic [CW-1:0] count;
  logic          dwell_tick;

  fnd_tick_gen #(
    .DIV (DIV),
    .CW  (CW)
  ) u_tick (
    .clk        (clk),
    .reset      (reset),
    .clr        (clr),
    .count      (count),
    .dwell_tick (dwell_tick)
  );

`ifdef FND_DIM_EN
  logic [2:0]  bright_q;
  logic [2:0]  bright_eff;
  logic [31:0] off_n;
  logic [31:0] duty;

  // Anode-on window for the cycle being registered: offset into DRIVE is
  // predicted from the current count because outputs are registered.
  always_comb begin
    bright_eff = (state_q == BLANK) ? bright : bright_q;
    off_n      = (state_q == DRIVE) ? (32'(count) + 32'd1 - BLANK_CYCLES) : '0;
    duty       = ((32'(bright_eff) + 32'd1) * (DIV - BLANK_CYCLES)) >> 3;
    lit        = (off_n < duty);
  end

  // Brightness is latched on entry to DRIVE so it is stable for the dwell.
  always_ff @(posedge clk) begin
    if (reset) begin
      bright_q <= '0;
    end else if (state_q == BLANK && state_n == DRIVE) begin
      bright_q <= bright;
    end
  end
`else
  assign lit = 1'b1;
`endif

  // Next-state, next-digit and registered-output precomputation.
  always_comb begin
    state_n = state_q;
    sel_n   = sel;
    fd_n    = 1'b0;
    clr     = 1'b0;
    nd      = next_digit(sel, digit_mask);
    if (!en || digit_mask == '0) begin
      state_n = IDLE;
      clr     = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          sel_n   = next_digit(3'd7, digit_mask);
          state_n = BLANK;
          clr     = 1'b1;
        end
        BLANK, DRIVE: begin
          if (!digit_mask[sel]) begin
            // Current digit withdrawn: skip ahead now rather than wait out the dwell.
            sel_n   = nd;
            fd_n    = (nd <= sel);
            state_n = BLANK;
            clr     = 1'b1;
          end else if (state_q == BLANK && count == CW'(BLANK_CYCLES - 1)) begin
            state_n = DRIVE;
          end else if (state_q == DRIVE && dwell_tick) begin
            sel_n   = nd;
            fd_n    = (nd <= sel);
            state_n = BLANK;
          end
        end
        default: begin
          state_n = IDLE;
          clr     = 1'b1;
        end
      endcase
    end
    an_nxt = 8'hFF;
    if (state_n == DRIVE && lit) begin
      an_nxt = onehot_low(sel_n);
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sel        <= '0;
      an_n       <= 8'hFF;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_n;
      sel        <= sel_n;
      an_n       <= an_nxt;
      frame_done <= fd_n;
    end
  end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Self-checking bench for fnd_scan_ctrl (DIV=10, BLANK_CYCLES=2).
module tb_fnd_scan_ctrl;

  localparam int CLK_HZ  = 1000;
  localparam int SCAN_HZ = 100;
  localparam int BLANK   = 2;
  localparam int DIV     = CLK_HZ / SCAN_HZ;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [7:0] mask;
  logic [2:0] sel;
  logic [7:0] an_n;
  logic       frame_done;
`ifdef FND_DIM_EN
  logic [2:0] bright;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: whether scanning, which digit, position within its dwell.
  bit         m_active;
  int         m_digit;
  int         m_pos;
  bit         m_fd;
  int         m_bright;
  logic [7:0] edge_mask;

  always #5 clk = ~clk;

  fnd_scan_ctrl #(
    .CLK_HZ       (CLK_HZ),
    .SCAN_HZ      (SCAN_HZ),
    .BLANK_CYCLES (BLANK),
    .NUM_DIGITS   (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .digit_mask (mask),
`ifdef FND_DIM_EN
    .bright     (bright),
`endif
    .sel        (sel),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  function automatic int next_on(int cur, logic [7:0] m);
    for (int k = 1; k <= 8; k++)
      if (m[(cur + k) % 8]) return (cur + k) % 8;
    return cur;
  endfunction

  function automatic logic [7:0] model_an();
    int on_len;
    logic [7:0] one;
    on_len = DIV - BLANK;
`ifdef FND_DIM_EN
    on_len = ((m_bright + 1) * (DIV - BLANK)) / 8;
`endif
    one = 8'd1;
    if (m_active && m_pos >= BLANK && (m_pos - BLANK) < on_len)
      return ~(one << m_digit);
    return 8'hFF;
  endfunction

  task automatic model_step();
    int nd;
    edge_mask = mask;
    m_fd = 1'b0;
    if (reset) begin
      m_active = 0; m_digit = 0; m_pos = 0;
    end else if (!en || mask == 8'h00) begin
      m_active = 0; m_pos = 0;
    end else if (!m_active) begin
      m_active = 1; m_digit = next_on(7, mask); m_pos = 0;
    end else if (!mask[m_digit] || m_pos == DIV - 1) begin
      nd = next_on(m_digit, mask);
      m_fd = (nd <= m_digit);
      m_digit = nd; m_pos = 0;
    end else begin
      m_pos++;
`ifdef FND_DIM_EN
      if (m_pos == BLANK) m_bright = bright;
`endif
    end
  endtask

  task automatic cycle();
    logic [7:0] exp_an;
    bit ok;
    @(posedge clk);
    model_step();
    @(negedge clk);
    exp_an = model_an();
    n_cmp++;
    assert (sel === 3'(m_digit)) else begin
      n_bad++; $error("FAIL sel got=%0d exp=%0d", sel, m_digit);
    end
    n_cmp++;
    assert (an_n === exp_an) else begin
      n_bad++; $error("FAIL an_n got=%h exp=%h", an_n, exp_an);
    end
    n_cmp++;
    assert (frame_done === m_fd) else begin
      n_bad++; $error("FAIL frame_done got=%b exp=%b", frame_done, m_fd);
    end
    ok = ($countones(~an_n) <= 1);
    for (int i = 0; i < 8; i++)
      if (an_n[i] === 1'b0 && !edge_mask[i]) ok = 0;
    n_cmp++;
    assert (ok === 1'b1) else begin
      n_bad++; $error("FAIL anode_invariant got=%h mask=%h", an_n, edge_mask);
    end
  endtask

  task automatic count_frames(input int cycles, input int expected, input string tag);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      cycle();
      if (frame_done === 1'b1) seen++;
    end
    n_cmp++;
    assert (seen === expected) else begin
      n_bad++; $error("FAIL %s frame_pulses got=%0d exp=%0d", tag, seen, expected);
    end
  endtask

  task automatic wait_driving(input int digit, input string tag);
    int g = 0;
    while (!(m_active && m_digit == digit && m_pos >= BLANK + 1) && g < 200) begin
      cycle();
      g++;
    end
    n_cmp++;
    assert (g < 200) else begin
      n_bad++; $error("FAIL %s timeout got=%0d exp=<200", tag, g);
    end
  endtask

  initial begin
    m_active = 0; m_digit = 0; m_pos = 0; m_fd = 0; m_bright = 7;
    reset = 1'b1; en = 1'b1; mask = 8'hFF;
`ifdef FND_DIM_EN
    bright = 3'd7;
`endif
    // Reset held 3 cycles
    for (int i = 0; i < 3; i++) cycle();
    reset = 1'b0;
    // Full mask scan
    for (int i = 0; i < 20; i++) cycle();
    count_frames(80, 1, "full_mask");
    // Sparse mask 2,5,7
    mask = 8'b1010_0100;
    for (int i = 0; i < 15; i++) cycle();
    count_frames(30, 1, "sparse_mask");
    // Single digit
    mask = 8'b0001_0000;
    for (int i = 0; i < 15; i++) cycle();
    count_frames(50, 5, "single_digit");
    // en drop while driving digit 3
    mask = 8'hFF;
    wait_driving(3, "wait_d3");
    en = 1'b0;
    cycle();
    n_cmp++;
    assert (an_n === 8'hFF && sel === 3'd3) else begin
      n_bad++; $error("FAIL en_drop got=%h/%0d exp=ff/3", an_n, sel);
    end
    cycle();
    en = 1'b1;
    for (int i = 0; i < 15; i++) cycle();
    // Withdraw digit 5 while it is driving
    wait_driving(5, "wait_d5");
    mask = 8'hDF;
    cycle();
    n_cmp++;
    assert (an_n === 8'hFF && sel === 3'd6) else begin
      n_bad++; $error("FAIL mask_clear got=%h/%0d exp=ff/6", an_n, sel);
    end
    for (int i = 0; i < 100; i++) cycle();
`ifdef FND_DIM_EN
    // Brightness levels on a single digit
    mask = 8'b0001_0000;
    bright = 3'd3;
    for (int i = 0; i < 40; i++) cycle();
    bright = 3'd0;
    for (int i = 0; i < 40; i++) cycle();
    bright = 3'd7;
    for (int i = 0; i < 40; i++) cycle();
`endif
    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      en    = ($urandom_range(0, 29) != 0);
      if ($urandom_range(0, 24) == 0) mask = 8'($urandom);
      if ($urandom_range(0, 7) == 0) mask = 8'h01 << $urandom_range(0, 7);
`ifdef FND_DIM_EN
      bright = 3'($urandom);
`endif
      cycle();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
